// File: rtl/ir_seq_pkg.sv
// Shared types and constants for the IR sensor round sequencer.
// Optional macro IR_FILTER_EN (see ir_sample_sequencer) does not affect this package.
package ir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CMD,
        CMD_WAIT,
        RD,
        RD_WAIT,
        DONE
    } ir_seq_state_t;

    localparam int TMR_W  = 18;
    localparam int NUM_CH = 8;
    localparam int RES_W  = 12;

    localparam logic [TMR_W-1:0] ROUND_CNT_FAST  = 18'h03fff;
    localparam logic [TMR_W-1:0] ROUND_CNT_FULL  = 18'h3ffff;
    localparam logic [TMR_W-1:0] SETTLE_CNT_FAST = 18'h007ff;
    localparam logic [TMR_W-1:0] SETTLE_CNT_FULL = 18'h00fff;

    // Channel map: ch0-3 are the left sensors L0-L3, ch4-7 the right sensors R0-R3.
    localparam logic [2:0] CH_L0 = 3'd0;
    localparam logic [2:0] CH_R3 = 3'd7;

    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/ir_round_timer.sv
// Free-running round/settle timer with synchronous clear, count enable and terminal-count compare.
// Independent of the IR_FILTER_EN build option.
module ir_round_timer
    import ir_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] term,
    output logic             tc
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + {{(TMR_W-1){1'b0}}, 1'b1};
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/ir_sample_sequencer.sv
// Schedules emitter power-up, settle delay and two A2D SPI transactions per IR channel each round.
// Define IR_FILTER_EN to average each new sample with the previous one (first round after reset loads raw).
module ir_sample_sequencer
    import ir_seq_pkg::*;
#(
    parameter bit          FAST_SIM    = 1'b0,
    parameter logic [11:0] LINE_THRESH = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        IR_en,
    output logic        IR_vld,
    output logic        line_present,
    output logic [95:0] ir_data
);

    localparam logic [TMR_W-1:0] ROUND_CNT  = FAST_SIM ? ROUND_CNT_FAST  : ROUND_CNT_FULL;
    localparam logic [TMR_W-1:0] SETTLE_CNT = FAST_SIM ? SETTLE_CNT_FAST : SETTLE_CNT_FULL;

    ir_seq_state_t state, state_nxt;
    logic [2:0] ch;
    logic [TMR_W-1:0] term;
    logic tmr_clr, tmr_en, tmr_tc;
    logic [NUM_CH-1:0][RES_W-1:0] bank;
    logic [RES_W-1:0] cap_val;
    logic any_above;
    logic unused_rd;

    assign unused_rd = ^spi_rd[15:12];

    ir_round_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .term (term),
        .tc   (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        term      = ROUND_CNT;
        case (state)
            IDLE: begin
                tmr_en = en;
                if (en && tmr_tc) begin
                    state_nxt = SETTLE;
                    tmr_clr   = 1'b1;
                end
            end
            SETTLE: begin
                term   = SETTLE_CNT;
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_nxt = CMD;
                    tmr_clr   = 1'b1;
                end
            end
            CMD:      state_nxt = CMD_WAIT;
            CMD_WAIT: if (spi_done) state_nxt = RD;
            RD:       state_nxt = RD_WAIT;
            RD_WAIT:  if (spi_done) state_nxt = (ch == CH_R3) ? DONE : CMD;
            DONE: begin
                state_nxt = IDLE;
                tmr_clr   = 1'b1;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Strobes are registered off the next state so they line up exactly with the CMD/RD/DONE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= CH_L0;
            spi_wrt      <= 1'b0;
            spi_cmd      <= '0;
            IR_en        <= 1'b0;
            IR_vld       <= 1'b0;
            line_present <= 1'b0;
        end else begin
            state   <= state_nxt;
            spi_wrt <= (state_nxt == CMD) || (state_nxt == RD);
            IR_vld  <= (state_nxt == DONE);
            if (state == IDLE && state_nxt == SETTLE) begin
                IR_en <= 1'b1;
            end
            if (state == SETTLE && state_nxt == CMD) begin
                ch      <= CH_L0;
                spi_cmd <= a2d_cmd(CH_L0);
            end
            if (state == RD_WAIT && state_nxt == CMD) begin
                ch      <= ch + 3'd1;
                spi_cmd <= a2d_cmd(ch + 3'd1);
            end
            if (state == DONE) begin
                IR_en        <= 1'b0;
                line_present <= any_above;
            end
        end
    end

`ifdef IR_FILTER_EN
    logic first_rnd;
    logic [RES_W:0] sum;

    assign sum     = {1'b0, bank[ch]} + {1'b0, spi_rd[11:0]};
    assign cap_val = first_rnd ? spi_rd[11:0] : sum[RES_W:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_rnd <= 1'b1;
        end else if (state == DONE) begin
            first_rnd <= 1'b0;
        end
    end
`else
    assign cap_val = spi_rd[11:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank <= '0;
        end else if (state == RD_WAIT && spi_done) begin
            bank[ch] <= cap_val;
        end
    end

    always_comb begin
        any_above = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bank[i] > LINE_THRESH) any_above = 1'b1;
        end
    end

    assign ir_data = bank;

endmodule

// File: tb/tb_ir_sample_sequencer.sv
// Randomized self-checking bench for ir_sample_sequencer (FAST_SIM=1) with an SPI slave model,
// a round-timeline reference model and literal checks; honours IR_FILTER_EN if defined.
module tb_ir_sample_sequencer;

    localparam int          ROUND_N  = 'h3fff;
    localparam int          SETTLE_N = 'h7ff;
    localparam logic [11:0] THRESH   = 12'h040;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd;
    logic        IR_en;
    logic        IR_vld;
    logic        line_present;
    logic [95:0] ir_data;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state (timeline of the current round)
    int          cyc = 0;
    bit          in_round;
    int          idle_cnt;
    int          first_wrt, exp_wrt, exp_vld, pend, n_done;
    logic [15:0] exp_cmd;
    logic [11:0] mdl  [8];
    logic [11:0] resp [8];
    bit          exp_en, exp_lp, first_rnd;
    int          mode = 1;
    bit          stray_on = 1'b0;

    ir_sample_sequencer #(.FAST_SIM(1'b1), .LINE_THRESH(12'h040)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .spi_wrt      (spi_wrt),
        .spi_cmd      (spi_cmd),
        .spi_done     (spi_done),
        .spi_rd       (spi_rd),
        .IR_en        (IR_en),
        .IR_vld       (IR_vld),
        .line_present (line_present),
        .ir_data      (ir_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        in_round  = 1'b0;
        idle_cnt  = 0;
        first_wrt = -1;
        exp_wrt   = -1;
        exp_vld   = -1;
        pend      = -1;
        n_done    = 0;
        exp_cmd   = 16'h0000;
        exp_en    = 1'b0;
        exp_lp    = 1'b0;
        first_rnd = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = 12'h000;
    endfunction

    function automatic void pick_resp();
        bit low;
        low = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < 8; i++) begin
            case (mode)
                1: resp[i] = 12'h100 + 12'(i);
                2: resp[i] = 12'h040;
                default: resp[i] = low ? 12'($urandom_range(0, 'h41)) : 12'($urandom);
            endcase
        end
`ifdef IR_FILTER_EN
        if (mode == 2) resp[0] = 12'h200;
`endif
    endfunction

    // Compare process plus SPI slave: checks every cycle, then drives spi_done for the coming edge.
    initial begin : compare_proc
        logic [95:0] exp_data;
        int          c;
        logic [11:0] raw;
        spi_done = 1'b0;
        spi_rd   = 16'h0000;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_reset();
                spi_done = 1'b0;
                chk("rst_spi_wrt", spi_wrt, 0);
                chk("rst_spi_cmd", spi_cmd, 0);
                chk("rst_ir_en", IR_en, 0);
                chk("rst_ir_vld", IR_vld, 0);
                chk("rst_line_present", line_present, 0);
                chk("rst_ir_data", ir_data, 0);
                continue;
            end
            if (cyc == exp_wrt) exp_cmd = 16'((n_done / 2) * 'h0800);
            for (int i = 0; i < 8; i++) exp_data[i*12 +: 12] = mdl[i];
            chk("spi_wrt", spi_wrt, cyc == exp_wrt);
            chk("spi_cmd", spi_cmd, exp_cmd);
            chk("ir_en", IR_en, exp_en);
            chk("ir_vld", IR_vld, cyc == exp_vld);
            chk("line_present", line_present, exp_lp);
            chk("ir_data", ir_data, exp_data);

            if (spi_wrt) pend = cyc + ((mode == 1) ? 20 : int'($urandom_range(1, 24)));
            spi_done = 1'b0;
            spi_rd   = 16'($urandom);
            if (in_round && cyc == pend) begin
                spi_done = 1'b1;
                if (n_done % 2 == 1) begin
                    c      = n_done / 2;
                    raw    = resp[c];
                    spi_rd = {4'($urandom), raw};
`ifdef IR_FILTER_EN
                    if (first_rnd) mdl[c] = raw;
                    else mdl[c] = 12'((int'(mdl[c]) + int'(raw)) / 2);
`else
                    mdl[c] = raw;
`endif
                end
                n_done++;
                if (n_done < 16) exp_wrt = cyc + 1;
                else exp_vld = cyc + 1;
                pend = -1;
            end else if (stray_on && (!in_round || cyc < first_wrt) && $urandom_range(0, 7) == 0) begin
                spi_done = 1'b1;
            end

            if (!in_round) begin
                if (en) begin
                    idle_cnt++;
                    if (idle_cnt == ROUND_N + 1) begin
                        in_round  = 1'b1;
                        exp_en    = 1'b1;
                        first_wrt = cyc + SETTLE_N + 2;
                        exp_wrt   = first_wrt;
                        n_done    = 0;
                        pick_resp();
                    end
                end
            end else if (cyc == exp_vld) begin
                in_round = 1'b0;
                idle_cnt = 0;
                exp_en   = 1'b0;
                exp_lp   = 1'b0;
                for (int i = 0; i < 8; i++) if (mdl[i] > THRESH) exp_lp = 1'b1;
                first_rnd = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          n;
        int          wrts;
        logic [15:0] cmds [16];
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b1;

        // Round 1: SPI returns 0x100+ch with 20-cycle latency
        n = 0;
        do begin @(negedge clk); n++; end while (!IR_en && n < 20000);
        chk("t1_ir_en_rise", n, 'h4001);
        n = 0;
        do begin @(negedge clk); n++; end while (!spi_wrt && n < 5000);
        chk("t1_first_wrt_gap", n, 'h800);
        chk("t1_first_cmd", spi_cmd, 16'h0000);
        wrts = 0;
        n = 0;
        while (!IR_vld && n < 3000) begin
            if (spi_wrt) begin
                if (wrts < 16) cmds[wrts] = spi_cmd;
                wrts++;
            end
            @(negedge clk);
            n++;
        end
        chk("t2_wrt_count", wrts, 16);
        chk("t2_cmd1", cmds[1], 16'h0000);
        chk("t2_cmd2", cmds[2], 16'h0800);
        chk("t2_cmd15", cmds[15], 16'h3800);
        chk("t2_vld", IR_vld, 1);
        chk("t2_ir_en_at_vld", IR_en, 1);
        mode = 2;
        stray_on = 1'b1;
        @(negedge clk);
        chk("t2_ir_en_fall", IR_en, 0);
        chk("t2_line_present", line_present, 1);
        chk("t2_ir_data", ir_data, {12'h107, 12'h106, 12'h105, 12'h104,
                                    12'h103, 12'h102, 12'h101, 12'h100});

        // Round 2: en dropped in IDLE and again mid-round; strays in IDLE/SETTLE
        repeat (10) @(posedge clk);
        #1 en = 1'b0;
        repeat (37) @(posedge clk);
        #1 en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!IR_en && n < 20000);
        @(posedge clk);
        #1 en = 1'b0;
        repeat (500) @(posedge clk);
        #1 en = 1'b1;
        n = 0;
        while (!IR_vld && n < 5000) begin @(negedge clk); n++; end
        chk("t3_vld", IR_vld, 1);
        mode = 0;
        @(negedge clk);
`ifdef IR_FILTER_EN
        chk("t6_ir0_filtered", ir_data[11:0], 12'h180);
`else
        chk("t3_line_present_strict", line_present, 0);
        chk("t3_ir_data", ir_data, {8{12'h040}});
`endif

        // Round 3: random data, reset during RD_WAIT of ch3
        n = 0;
        do begin @(negedge clk); n++; end while (!IR_en && n < 20000);
        wrts = 0;
        n = 0;
        while (wrts < 8 && n < 5000) begin
            @(negedge clk);
            n++;
            if (spi_wrt) wrts++;
        end
        chk("t5_reached_rd_ch3", wrts, 8);
        chk("t5_cmd_ch3", spi_cmd, 16'h1800);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ir_data", ir_data, 96'h0);
        chk("t5_rst_ir_en", IR_en, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Round 4: full ROUND_CNT again after reset, random data
        n = 0;
        do begin @(negedge clk); n++; end while (!IR_en && n < 20000);
        chk("t5_next_round_start", n, 'h4001);
        n = 0;
        while (!IR_vld && n < 5000) begin @(negedge clk); n++; end
        chk("t5_vld", IR_vld, 1);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
